updown_decoder: RTL and testbench
=================================

Name: updown_decoder

Overview:
- Reader-side companion to the 4-bit up/down loadable counter.
- Samples the counter's count bus each enabled cycle and reconstructs the counter's activity from consecutive samples: count-up step, count-down step, hold, parallel load, and wrap-around.
- Keeps saturating event tallies, so monitors and on-chip checkers can infer load/control activity without access to the counter's inputs.

Parameters:
- WIDTH, 4, width of the observed count bus; legal range is WIDTH >= 2.
- EVT_W, 8, width of each saturating event tally.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous reset, active-low.
- clr  in  1  synchronous clear of tallies and tracking state.
- en  in  1  count_in is valid this cycle.
- count_in  in  WIDTH  observed counter value.
- dir  out  1  last inferred direction: 1 = up, 0 = down.
- step_up  out  1  one-cycle pulse: sample = previous + 1.
- step_dn  out  1  one-cycle pulse: sample = previous - 1.
- hold  out  1  one-cycle pulse: sample = previous.
- load_det  out  1  one-cycle pulse: any other delta (parallel load inferred).
- wrap  out  1  one-cycle pulse: the step crossed max->0 (up) or 0->max (down).
- load_val  out  WIDTH  value captured at the last load_det.
- up_cnt  out  EVT_W  saturating count of step_up events.
- dn_cnt  out  EVT_W  saturating count of step_dn events.
- ld_cnt  out  EVT_W  saturating count of load_det events.
- synced  out  1  a reference sample is held (state != INIT).

Behaviour:
- Reset (rst=0, asynchronous)
  - All outputs are 0. prev register is 0. State is INIT.
  - On deassertion, the first edge with en=1 captures a reference.
- State machine: INIT, UP, DOWN, STILL.
  - INIT, en=1: capture count_in into prev; go to STILL; no pulses; synced=1 from the next cycle.
  - Any tracking state (UP, DOWN, STILL), en=1: compute delta = (count_in - prev) mod 2^WIDTH and act on it:
    - delta = 1: step_up; state UP; dir=1.
    - delta = 2^WIDTH-1: step_dn; state DOWN; dir=0.
    - delta = 0: hold; state STILL; dir unchanged.
    - any other delta: load_det; load_val=count_in; state STILL; dir unchanged.
  - In every tracking case prev <= count_in.
  - en=0: no sample, prev and state held, all pulses 0.
- Latency: a sample taken at edge N produces its pulses and updated dir, load_val and tallies in the cycle after edge N. Pulses last exactly one cycle. At most one of step_up/step_dn/hold/load_det is high in any cycle.
- wrap:
  - Asserted together with step_up when prev = 2^WIDTH-1 and count_in = 0.
  - Asserted together with step_dn when prev = 0 and count_in = 2^WIDTH-1.
  - Never asserted with load_det or hold.
- Tallies: each increments by 1 on its event and saturates at 2^EVT_W-1 (no rollover).
- clr (synchronous):
  - Zeroes tallies, load_val, dir and the pulses; state goes to INIT.
  - clr with en in the same cycle: clr wins and the sample is discarded.
- Reset mid-operation: asynchronous return to the reset values; the in-flight sample is lost.
- Arithmetic: delta is a WIDTH-bit modular subtraction; no sign extension.

Decomposition:
- Shared package updown_pkg:
  - state enum (INIT, UP, DOWN, STILL);
  - DEFAULT_WIDTH=4 and DEFAULT_EVT_W=8;
  - step-class encoding (CLS_UP, CLS_DN, CLS_HOLD, CLS_LOAD).
- One sub-module sat_counter (parameter EVT_W; ports clk, rst, clr, inc, value), instantiated three times for up_cnt, dn_cnt and ld_cnt.
- Delta classification and the FSM stay in updown_decoder.

Test Plan:
1. Reset, then en=1 with count_in=3,4,5,6 -> synced=1 after the first sample; three step_up pulses; dir=1; up_cnt=3; no other pulses.
2. count_in = 14,15,0,1 (WIDTH=4) -> step_up each cycle; wrap asserted only on the 15->0 step; then 1,0,15 -> step_dn twice, wrap on 0->15, dir=0, dn_cnt=2.
3. Sequence 2,9,9 -> load_det on 2->9 with load_val=9 and ld_cnt=1; then hold on 9->9; dir unchanged from its previous value.
4. en toggled 1,0,0,1 with count_in 5,X,X,6 -> no pulses while en=0; step_up on the 6 sample (compared against 5).
5. Drive 300 consecutive up steps with EVT_W=8 -> up_cnt saturates at 255 with no rollover; then clr with en=1 -> tallies 0, state INIT, that sample ignored, the next sample only re-references.
6. rst pulled low mid-sequence between two up steps -> all outputs 0 immediately (asynchronous); after release the first sample gives no pulse and synced=1.

Source files
------------

// File: rtl/updown_pkg.sv
// Shared types and defaults for the up/down counter observer.
package updown_pkg;

    localparam int unsigned DEFAULT_WIDTH = 4;
    localparam int unsigned DEFAULT_EVT_W = 8;

    // Tracking state: INIT holds no reference sample yet.
    typedef enum logic [1:0] {
        INIT  = 2'd0,
        UP    = 2'd1,
        DOWN  = 2'd2,
        STILL = 2'd3
    } state_e;

    // Classification of the modular delta between two consecutive samples.
    typedef enum logic [1:0] {
        CLS_UP   = 2'd0,
        CLS_DN   = 2'd1,
        CLS_HOLD = 2'd2,
        CLS_LOAD = 2'd3
    } step_cls_e;

endpackage

// File: rtl/sat_counter.sv
// Saturating event tally.
//   clk   : rising-edge clock
//   rst   : asynchronous reset, active-low
//   clr   : synchronous clear to zero (wins over inc)
//   inc   : add one this cycle unless already at all-ones
//   value : current tally
module sat_counter #(
    parameter int unsigned EVT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             inc,
    output logic [EVT_W-1:0] value
);

    localparam logic [EVT_W-1:0] MAX_VAL = '1;
    localparam logic [EVT_W-1:0] ONE     = EVT_W'(1);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            value <= '0;
        end else if (clr) begin
            value <= '0;
        end else if (inc && (value != MAX_VAL)) begin
            value <= value + ONE;
        end
    end

endmodule

// File: rtl/updown_decoder.sv
// Reconstructs up/down counter activity from consecutive samples of its
// count bus: step up/down, hold, parallel load and wrap-around, with
// saturating tallies of each step kind.
//   clk, rst (async active-low), clr (sync clear), en (sample valid)
//   count_in   : observed counter value
//   dir        : last inferred direction (1 = up)
//   step_up/step_dn/hold/load_det/wrap : one-cycle event pulses
//   load_val   : value captured at the last inferred load
//   up_cnt/dn_cnt/ld_cnt : saturating event tallies
//   synced     : a reference sample is held
module updown_decoder
    import updown_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH,
    parameter int unsigned EVT_W = DEFAULT_EVT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    input  logic [WIDTH-1:0] count_in,
    output logic             dir,
    output logic             step_up,
    output logic             step_dn,
    output logic             hold,
    output logic             load_det,
    output logic             wrap,
    output logic [WIDTH-1:0] load_val,
    output logic [EVT_W-1:0] up_cnt,
    output logic [EVT_W-1:0] dn_cnt,
    output logic [EVT_W-1:0] ld_cnt,
    output logic             synced
);

    localparam logic [WIDTH-1:0] MAX_VAL = '1;
    localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);

    state_e           state_q,    state_d;
    logic [WIDTH-1:0] prev_q,     prev_d;
    logic [WIDTH-1:0] load_val_q, load_val_d;
    logic             dir_q,      dir_d;
    logic             synced_q,   synced_d;
    logic             step_up_q,  step_up_d;
    logic             step_dn_q,  step_dn_d;
    logic             hold_q,     hold_d;
    logic             load_det_q, load_det_d;
    logic             wrap_q,     wrap_d;

    logic [WIDTH-1:0] delta_c;
    step_cls_e        cls_c;

    // Modular difference; WIDTH >= 2 keeps +1 and -1 distinct.
    always_comb begin
        delta_c = count_in - prev_q;
        if (delta_c == ONE) begin
            cls_c = CLS_UP;
        end else if (delta_c == MAX_VAL) begin
            cls_c = CLS_DN;
        end else if (delta_c == '0) begin
            cls_c = CLS_HOLD;
        end else begin
            cls_c = CLS_LOAD;
        end
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= INIT;
            prev_q     <= '0;
            load_val_q <= '0;
            dir_q      <= 1'b0;
            synced_q   <= 1'b0;
            step_up_q  <= 1'b0;
            step_dn_q  <= 1'b0;
            hold_q     <= 1'b0;
            load_det_q <= 1'b0;
            wrap_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            prev_q     <= prev_d;
            load_val_q <= load_val_d;
            dir_q      <= dir_d;
            synced_q   <= synced_d;
            step_up_q  <= step_up_d;
            step_dn_q  <= step_dn_d;
            hold_q     <= hold_d;
            load_det_q <= load_det_d;
            wrap_q     <= wrap_d;
        end
    end

    // Next-state and next-output logic; clr discards any same-cycle sample.
    always_comb begin
        state_d    = state_q;
        prev_d     = prev_q;
        load_val_d = load_val_q;
        dir_d      = dir_q;
        step_up_d  = 1'b0;
        step_dn_d  = 1'b0;
        hold_d     = 1'b0;
        load_det_d = 1'b0;
        wrap_d     = 1'b0;

        if (clr) begin
            state_d    = INIT;
            load_val_d = '0;
            dir_d      = 1'b0;
        end else if (en) begin
            prev_d = count_in;
            case (state_q)
                INIT: begin
                    state_d = STILL;
                end
                default: begin
                    case (cls_c)
                        CLS_UP: begin
                            state_d   = UP;
                            dir_d     = 1'b1;
                            step_up_d = 1'b1;
                            wrap_d    = (prev_q == MAX_VAL);
                        end
                        CLS_DN: begin
                            state_d   = DOWN;
                            dir_d     = 1'b0;
                            step_dn_d = 1'b1;
                            wrap_d    = (prev_q == '0);
                        end
                        CLS_HOLD: begin
                            state_d = STILL;
                            hold_d  = 1'b1;
                        end
                        default: begin
                            state_d    = STILL;
                            load_det_d = 1'b1;
                            load_val_d = count_in;
                        end
                    endcase
                end
            endcase
        end

        synced_d = (state_d != INIT);
    end

    // Tallies advance on the same edge that registers the matching pulse.
    sat_counter #(.EVT_W(EVT_W)) u_up_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr   (clr),
        .inc   (step_up_d),
        .value (up_cnt)
    );

    sat_counter #(.EVT_W(EVT_W)) u_dn_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr   (clr),
        .inc   (step_dn_d),
        .value (dn_cnt)
    );

    sat_counter #(.EVT_W(EVT_W)) u_ld_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr   (clr),
        .inc   (load_det_d),
        .value (ld_cnt)
    );

    assign dir      = dir_q;
    assign step_up  = step_up_q;
    assign step_dn  = step_dn_q;
    assign hold     = hold_q;
    assign load_det = load_det_q;
    assign wrap     = wrap_q;
    assign load_val = load_val_q;
    assign synced   = synced_q;

endmodule

// File: tb/tb_updown_decoder.sv
// Bench for updown_decoder: vector table plus hand-written corner sequences,
// expected outputs queued at drive time and compared after the clock edge.
module tb_updown_decoder;

    localparam int unsigned WIDTH = 4;
    localparam int unsigned EVT_W = 8;

    typedef struct packed {
        logic             su;
        logic             sd;
        logic             h;
        logic             ld;
        logic             wr;
        logic             dir;
        logic             sync;
        logic [WIDTH-1:0] lv;
        logic [EVT_W-1:0] uc;
        logic [EVT_W-1:0] dc;
        logic [EVT_W-1:0] lc;
    } out_t;

    typedef struct packed {
        logic             clr;
        logic             en;
        logic [WIDTH-1:0] cin;
        out_t             exp;
    } vec_t;

    logic             clk = 1'b0;
    logic             rst;
    logic             clr;
    logic             en;
    logic [WIDTH-1:0] count_in;
    logic             dir;
    logic             step_up;
    logic             step_dn;
    logic             hold;
    logic             load_det;
    logic             wrap;
    logic [WIDTH-1:0] load_val;
    logic [EVT_W-1:0] up_cnt;
    logic [EVT_W-1:0] dn_cnt;
    logic [EVT_W-1:0] ld_cnt;
    logic             synced;

    out_t exp_q[$];
    vec_t tbl[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    updown_decoder #(.WIDTH(WIDTH), .EVT_W(EVT_W)) dut (
        .clk      (clk),
        .rst      (rst),
        .clr      (clr),
        .en       (en),
        .count_in (count_in),
        .dir      (dir),
        .step_up  (step_up),
        .step_dn  (step_dn),
        .hold     (hold),
        .load_det (load_det),
        .wrap     (wrap),
        .load_val (load_val),
        .up_cnt   (up_cnt),
        .dn_cnt   (dn_cnt),
        .ld_cnt   (ld_cnt),
        .synced   (synced)
    );

    always #5 clk = ~clk;

    function automatic out_t mk(input logic su, sd, h, ld, wr, d, s,
                                input int lv, uc, dc, lc);
        out_t o;
        o.su   = su;
        o.sd   = sd;
        o.h    = h;
        o.ld   = ld;
        o.wr   = wr;
        o.dir  = d;
        o.sync = s;
        o.lv   = WIDTH'(lv);
        o.uc   = EVT_W'(uc);
        o.dc   = EVT_W'(dc);
        o.lc   = EVT_W'(lc);
        return o;
    endfunction

    function automatic out_t actual();
        return {step_up, step_dn, hold, load_det, wrap, dir, synced,
                load_val, up_cnt, dn_cnt, ld_cnt};
    endfunction

    task automatic add(input logic c, e, input int cin, input out_t x);
        vec_t v;
        v.clr = c;
        v.en  = e;
        v.cin = WIDTH'(cin);
        v.exp = x;
        tbl.push_back(v);
    endtask

    task automatic check(input string name);
        out_t e;
        out_t a;
        n_checks++;
        if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL %s: scoreboard empty", name);
        end else begin
            e = exp_q.pop_front();
            a = actual();
            if (a !== e) begin
                n_fail++;
                $display("FAIL %s: got su=%b sd=%b h=%b ld=%b wr=%b dir=%b sync=%b lv=%0d up=%0d dn=%0d lc=%0d, expected su=%b sd=%b h=%b ld=%b wr=%b dir=%b sync=%b lv=%0d up=%0d dn=%0d lc=%0d",
                         name, a.su, a.sd, a.h, a.ld, a.wr, a.dir, a.sync, a.lv, a.uc, a.dc, a.lc,
                         e.su, e.sd, e.h, e.ld, e.wr, e.dir, e.sync, e.lv, e.uc, e.dc, e.lc);
            end
        end
    endtask

    // Drive one cycle of stimulus at negedge, compare just after the next posedge.
    task automatic drive(input logic c, e, input logic [WIDTH-1:0] v,
                         input out_t x, input string name);
        @(negedge clk);
        clr      = c;
        en       = e;
        count_in = v;
        exp_q.push_back(x);
        @(posedge clk);
        #1;
        check(name);
    endtask

    initial begin
        out_t z;
        z = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

        rst      = 1'b0;
        clr      = 1'b0;
        en       = 1'b0;
        count_in = '0;
        #1;
        exp_q.push_back(z);
        check("reset_state");
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;

        //           clr en cin   su sd h  ld wr dir sync lv up dn lc
        add(0, 1,  3, mk(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0));
        add(0, 1,  4, mk(1, 0, 0, 0, 0, 1, 1, 0, 1, 0, 0));
        add(0, 1,  5, mk(1, 0, 0, 0, 0, 1, 1, 0, 2, 0, 0));
        add(0, 1,  6, mk(1, 0, 0, 0, 0, 1, 1, 0, 3, 0, 0));
        add(1, 0,  0, mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        add(0, 1, 14, mk(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0));
        add(0, 1, 15, mk(1, 0, 0, 0, 0, 1, 1, 0, 1, 0, 0));
        add(0, 1,  0, mk(1, 0, 0, 0, 1, 1, 1, 0, 2, 0, 0));
        add(0, 1,  1, mk(1, 0, 0, 0, 0, 1, 1, 0, 3, 0, 0));
        add(0, 1,  0, mk(0, 1, 0, 0, 0, 0, 1, 0, 3, 1, 0));
        add(0, 1, 15, mk(0, 1, 0, 0, 1, 0, 1, 0, 3, 2, 0));
        add(0, 1,  2, mk(0, 0, 0, 1, 0, 0, 1, 2, 3, 2, 1));
        add(0, 1,  3, mk(1, 0, 0, 0, 0, 1, 1, 2, 4, 2, 1));
        add(0, 1,  9, mk(0, 0, 0, 1, 0, 1, 1, 9, 4, 2, 2));
        add(0, 1,  9, mk(0, 0, 1, 0, 0, 1, 1, 9, 4, 2, 2));
        add(0, 1,  5, mk(0, 0, 0, 1, 0, 1, 1, 5, 4, 2, 3));
        add(0, 0,  7, mk(0, 0, 0, 0, 0, 1, 1, 5, 4, 2, 3));
        add(0, 0,  0, mk(0, 0, 0, 0, 0, 1, 1, 5, 4, 2, 3));
        add(0, 1,  6, mk(1, 0, 0, 0, 0, 1, 1, 5, 5, 2, 3));
        add(0, 1,  5, mk(0, 1, 0, 0, 0, 0, 1, 5, 5, 3, 3));
        add(1, 1,  7, mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        add(0, 1,  8, mk(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0));
        add(0, 1,  9, mk(1, 0, 0, 0, 0, 1, 1, 0, 1, 0, 0));

        for (int i = 0; i < tbl.size(); i++) begin
            drive(tbl[i].clr, tbl[i].en, tbl[i].cin, tbl[i].exp,
                  $sformatf("vec%0d", i));
        end

        // Saturation: 300 up steps from a fresh reference of 0.
        drive(1, 0, 0, z, "sat_clr");
        drive(0, 1, 0, mk(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0), "sat_ref");
        for (int k = 1; k <= 300; k++) begin
            drive(0, 1, WIDTH'(k % 16),
                  mk(1, 0, 0, 0, ((k % 16) == 0), 1, 1, 0, (k > 255) ? 255 : k, 0, 0),
                  $sformatf("sat_step%0d", k));
        end
        drive(1, 1, 5, z, "clr_with_en");
        drive(0, 1, 9, mk(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0), "rereference");
        drive(0, 1, 10, mk(1, 0, 0, 0, 0, 1, 1, 0, 1, 0, 0), "post_clr_up");
        drive(0, 1, 11, mk(1, 0, 0, 0, 0, 1, 1, 0, 2, 0, 0), "pre_rst_up");

        // Asynchronous reset between two up steps.
        @(negedge clk);
        en       = 1'b1;
        count_in = WIDTH'(12);
        rst      = 1'b0;
        #1;
        exp_q.push_back(z);
        check("async_rst_now");
        @(posedge clk);
        #1;
        exp_q.push_back(z);
        check("async_rst_held");
        @(negedge clk);
        en  = 1'b0;
        rst = 1'b1;
        drive(0, 1, 13, mk(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0), "post_rst_ref");
        drive(0, 1, 14, mk(1, 0, 0, 0, 0, 1, 1, 0, 1, 0, 0), "post_rst_up");

        if (exp_q.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL scoreboard_drain: %0d left, expected 0", exp_q.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
